// File: rtl/ecc_read_pipe_pkg.sv
// Shared SECDED types and codeword layout for the Hamming memory controller read path.
// cw[0] is overall parity, powers of two are Hamming parity, data fills the remaining slots ascending.
package ecc_read_pipe_pkg;
    localparam int D_W  = 32;
    localparam int A_W  = 16;
    localparam int P_W  = 6;
    localparam int CW_W = D_W + P_W + 1;
    localparam int R_LAT [2] = '{5, 3};

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        ONE  = 2'd1,
        TWO  = 2'd2
    } error_type;

    // Codeword position of data bit k: k-th non-power-of-two slot from 3 upward.
    function automatic int data_pos(input int k);
        int pos;
        int n;
        pos = 0;
        n   = 0;
        for (int i = 3; i < CW_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == k) pos = i;
                n++;
            end
        end
        return pos;
    endfunction
endpackage

// File: rtl/ecc_read_pipe_if.sv
// Read-return bus of one controller port: raw codeword in, corrected word out, counters, scrub handshake.
// master drives the array side and scrub_ready; slave is the read pipe.
interface ecc_read_pipe_if
    import ecc_read_pipe_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [A_W-1:0]   in_addr;
    logic [CW_W-1:0]  in_cw;
    logic             out_valid;
    logic [A_W-1:0]   out_addr;
    logic [D_W-1:0]   out_data;
    error_type        out_err;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_one;
    logic [CNT_W-1:0] cnt_two;
    logic             scrub_valid;
    logic             scrub_ready;
    logic [A_W-1:0]   scrub_addr;
    logic [CW_W-1:0]  scrub_cw;
    logic             scrub_drop;

    modport master (
        output in_valid, in_addr, in_cw, cnt_clr, scrub_ready,
        input  out_valid, out_addr, out_data, out_err, cnt_one, cnt_two,
               scrub_valid, scrub_addr, scrub_cw, scrub_drop
    );

    modport slave (
        input  in_valid, in_addr, in_cw, cnt_clr, scrub_ready,
        output out_valid, out_addr, out_data, out_err, cnt_one, cnt_two,
               scrub_valid, scrub_addr, scrub_cw, scrub_drop
    );
endinterface

// File: rtl/ecc_read_pipe_dec.sv
// ecc_secded_dec: combinational SECDED check/correct; TWO results pass the raw codeword through.
// Zero latency, no handshake.
module ecc_secded_dec
    import ecc_read_pipe_pkg::*;
(
    input  logic [CW_W-1:0] cw_i,
    output logic [D_W-1:0]  data_o,
    output logic [CW_W-1:0] cw_fix_o,
    output error_type       err_o
);
    logic [P_W-1:0] syn;
    logic           par;

    always_comb begin
        syn = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (cw_i[i]) syn = syn ^ P_W'(i);
        end
        par = ^cw_i;
    end

    always_comb begin
        cw_fix_o = cw_i;
        err_o    = ZERO;
        if (par) begin
            // syn == 0 lands on cw[0], the overall parity bit itself
            if (syn < P_W'(CW_W)) begin
                cw_fix_o = cw_i ^ (CW_W'(1) << syn);
                err_o    = ONE;
            end else begin
                err_o = TWO;
            end
        end else if (syn != '0) begin
            err_o = TWO;
        end
        data_o = '0;
        for (int k = 0; k < D_W; k++) data_o[k] = cw_fix_o[data_pos(k)];
    end
endmodule

// File: rtl/ecc_read_pipe.sv
// Read-return stage: LAT-1 plain delay stages then registered SECDED decode; read path never stalls.
// ECC_SCRUB_EN adds a one-entry scrub buffer held until scrub_ready; otherwise scrub outputs are tied low.
module ecc_read_pipe
    import ecc_read_pipe_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int LAT     = R_LAT[PORT_ID],
    parameter int CNT_W   = 16
) (
    input logic            clk,
    input logic            rst,
    ecc_read_pipe_if.slave bus
);
    localparam int DLY = LAT - 1;

    logic            dly_vld_q  [DLY];
    logic [A_W-1:0]  dly_addr_q [DLY];
    logic [CW_W-1:0] dly_cw_q   [DLY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) dly_vld_q[i] <= 1'b0;
        end else begin
            dly_vld_q[0] <= bus.in_valid;
            for (int i = 1; i < DLY; i++) dly_vld_q[i] <= dly_vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dly_addr_q[0] <= bus.in_addr;
        dly_cw_q[0]   <= bus.in_cw;
        for (int i = 1; i < DLY; i++) begin
            dly_addr_q[i] <= dly_addr_q[i-1];
            dly_cw_q[i]   <= dly_cw_q[i-1];
        end
    end

    logic [D_W-1:0]  dec_data;
    logic [CW_W-1:0] dec_cw;
    error_type       dec_err;

    ecc_secded_dec u_dec (
        .cw_i     (dly_cw_q[DLY-1]),
        .data_o   (dec_data),
        .cw_fix_o (dec_cw),
        .err_o    (dec_err)
    );

    logic            out_vld_q;
    logic [A_W-1:0]  out_addr_q;
    logic [D_W-1:0]  out_data_q;
    error_type       out_err_q;
    logic [CW_W-1:0] out_cw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_err_q  <= ZERO;
        end else begin
            out_vld_q <= dly_vld_q[DLY-1];
            if (dly_vld_q[DLY-1]) begin
                out_addr_q <= dly_addr_q[DLY-1];
                out_data_q <= dec_data;
                out_err_q  <= dec_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dly_vld_q[DLY-1]) out_cw_q <= dec_cw;
    end

    logic             hit_one;
    logic             hit_two;
    logic [CNT_W-1:0] cnt_one_q, cnt_one_d;
    logic [CNT_W-1:0] cnt_two_q, cnt_two_d;

    assign hit_one = out_vld_q && (out_err_q == ONE);
    assign hit_two = out_vld_q && (out_err_q == TWO);

    always_comb begin
        cnt_one_d = cnt_one_q;
        cnt_two_d = cnt_two_q;
        if (bus.cnt_clr) begin
            cnt_one_d = '0;
            cnt_two_d = '0;
        end else begin
            if (hit_one && cnt_one_q != '1) cnt_one_d = cnt_one_q + CNT_W'(1);
            if (hit_two && cnt_two_q != '1) cnt_two_d = cnt_two_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_one_q <= '0;
            cnt_two_q <= '0;
        end else begin
            cnt_one_q <= cnt_one_d;
            cnt_two_q <= cnt_two_d;
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.cnt_one   = cnt_one_q;
    assign bus.cnt_two   = cnt_two_q;

`ifdef ECC_SCRUB_EN
    logic            scrub_vld_q, scrub_vld_d;
    logic            scrub_drop_q, scrub_drop_d;
    logic [A_W-1:0]  scrub_addr_q, scrub_addr_d;
    logic [CW_W-1:0] scrub_cw_q, scrub_cw_d;

    // Drop is registered so it lines up with the cycle the entry would have appeared.
    always_comb begin
        scrub_vld_d  = scrub_vld_q;
        scrub_addr_d = scrub_addr_q;
        scrub_cw_d   = scrub_cw_q;
        scrub_drop_d = hit_one && scrub_vld_q && !bus.scrub_ready;
        if (hit_one && (!scrub_vld_q || bus.scrub_ready)) begin
            scrub_vld_d  = 1'b1;
            scrub_addr_d = out_addr_q;
            scrub_cw_d   = out_cw_q;
        end else if (scrub_vld_q && bus.scrub_ready) begin
            scrub_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_vld_q  <= 1'b0;
            scrub_drop_q <= 1'b0;
            scrub_addr_q <= '0;
            scrub_cw_q   <= '0;
        end else begin
            scrub_vld_q  <= scrub_vld_d;
            scrub_drop_q <= scrub_drop_d;
            scrub_addr_q <= scrub_addr_d;
            scrub_cw_q   <= scrub_cw_d;
        end
    end

    assign bus.scrub_valid = scrub_vld_q;
    assign bus.scrub_drop  = scrub_drop_q;
    assign bus.scrub_addr  = scrub_addr_q;
    assign bus.scrub_cw    = scrub_cw_q;
`else
    logic unused_scrub;
    assign unused_scrub    = ^{bus.scrub_ready, out_cw_q};
    assign bus.scrub_valid = 1'b0;
    assign bus.scrub_drop  = 1'b0;
    assign bus.scrub_addr  = '0;
    assign bus.scrub_cw    = '0;
`endif
endmodule

// File: doc/ecc_read_pipe.md
# ecc_read_pipe

Read-return stage of the dual-port Hamming memory controller. Takes the raw SECDED codeword read from the array for one port, delays it to that port's read latency, decodes and corrects it, and presents corrected data with an error classification. Also keeps saturating error counters and, optionally, queues a scrub write-back for corrected single-bit errors. One instance per port.

## Interface
- PORT_ID, 0: selects `param::R_LAT[PORT_ID]` as pipeline depth (0 = PORTA, 1 = PORTB)
- LAT, `param::R_LAT[PORT_ID]`: total in->out latency in cycles; legal range ≥ 2
- CNT_W, 16: error counter width

Ports:
- clk  in  1  port clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  codeword returned from array this cycle
- in_addr  in  A_W  address of returned word
- in_cw  in  CW_W  raw codeword (CW_W = D_W+P_W+1 = 39)
- out_valid  out  1  corrected word valid
- out_addr  out  A_W  address, delayed with the word
- out_data  out  D_W  corrected data
- out_err  out  2  `error_type`: ZERO, ONE or TWO
- cnt_clr  in  1  clear both counters
- cnt_one  out  CNT_W  saturating count of ONE results
- cnt_two  out  CNT_W  saturating count of TWO results
- scrub_valid  out  1  scrub write-back pending
- scrub_ready  in  1  write arbiter accepts scrub
- scrub_addr  out  A_W  scrub address
- scrub_cw  out  CW_W  corrected codeword to write
- scrub_drop  out  1  one-cycle pulse: ONE result not queued because buffer full

## Operation
- Codeword layout: cw[0] = overall even parity over cw[38:1]; cw[1,2,4,8,16,32] = Hamming parity; data bits d0..d31 fill remaining positions 3,5,6,7,9,… ascending.
- Syndrome s = XOR of indices i∈[1,38] with cw[i]=1; overall p = ^cw[38:0].
- p=0, s=0 → ZERO, data as-is. p=1, s=0 → ONE, cw[0] flipped, data unchanged. p=1, 1≤s≤38 → ONE, bit s flipped. p=1, s>38 → TWO. p=0, s≠0 → TWO.
- TWO: out_data = uncorrected data field; no scrub.
- Fully pipelined: one word accepted per cycle, no backpressure on read path; in_valid never stalls.
- Counters: increment on out_valid with ONE/TWO; hold at all-ones; cnt_clr wins over same-cycle increment (result 0).
- Scrub buffer (one entry): on out_valid & ONE & (empty or scrub_ready this cycle) load {out_addr, corrected cw}; full & !scrub_ready & new ONE → scrub_drop=1, entry unchanged. Handshake completes on scrub_valid & scrub_ready; scrub_valid held with stable payload until then.

## Timing
- out_valid rises exactly LAT cycles after in_valid sampled high; out_* registered.
- Decode occurs in final pipeline stage; earlier LAT-1 stages are plain delay.
- scrub_valid rises the cycle after the ONE result's out_valid.
- Reset: all stage valids, out_valid, out_err=ZERO, out_data=0, out_addr=0, counters=0, scrub_valid=0, scrub_drop=0. Reset mid-operation discards in-flight words; no output for them after rst deasserts.
- Back-to-back ONE results with scrub_ready held high: every one queued, no drops.

## Configuration
- ECC_SCRUB_EN defined: scrub buffer and handshake as above.
- Undefined: scrub_valid, scrub_drop, scrub_addr, scrub_cw tied 0; scrub_ready ignored; decode and counters unchanged.

## Structure
- Add to shared package: P_W=6, CW_W=D_W+P_W+1, and reuse `error_type`; encoder and decoder must agree on layout, so define layout constants there.
- One sub-module: `ecc_secded_dec` (combinational: cw → data, corrected cw, error_type).

## Test plan
- Clean word: encode 32'hDEADBEEF, in_valid at cycle 0 → out_valid at cycle LAT, out_data 32'hDEADBEEF, out_err ZERO, counters 0.
- Single flip at position 3 (d0) → out_data 32'hDEADBEEF, out_err ONE, cnt_one=1, scrub_valid next cycle with scrub_cw = clean codeword.
- Flip positions 3 and 5 → out_err TWO, cnt_two=1, no scrub, out_data = corrupted data.
- Flip cw[0] only → ONE, data unchanged; two ONEs back-to-back with scrub_ready=0 → second gives scrub_drop pulse, buffer keeps first address.
- Preset counter to 16'hFFFF then ONE → stays 16'hFFFF; cnt_clr with same-cycle ONE → 0.
- rst asserted 1 cycle after in_valid (LAT=5) → no out_valid for that word; all outputs at reset values.
